text_writer: RTL and testbench



---
 rtl/text_writer.sv | 184 ++++++++++++++++++
 tb/tb_text_writer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/text_writer.sv
// text_writer: byte-stream console writer for the 80x25 text video RAM.
// Ports: clock, reset (async high), data/attr/valid/ready byte input,
// mem_address/mem_out/mem_we/mem_in RAM port, cursor cell index.
// Build option: TEXT_WRITER_SCROLL_EN enables hardware scrolling.
module text_writer (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data,
    input  logic [7:0]  attr,
    input  logic        valid,
    output logic        ready,
    output logic [11:0] mem_address,
    output logic [7:0]  mem_out,
    output logic        mem_we,
    input  logic [7:0]  mem_in,
    output logic [10:0] cursor
);

`ifdef TEXT_WRITER_SCROLL_EN
    typedef enum logic [2:0] {
        IDLE, WCHR, WATR, SCRD, SCWR, FILL, CLR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, WCHR, WATR, CLR
    } state_t;
`endif

    state_t      state;
    logic [7:0]  lat_d;
    logic [7:0]  lat_a;
    logic [6:0]  col;

`ifdef TEXT_WRITER_SCROLL_EN
    // High when the previous cycle was a read, i.e. mem_in now holds
    // the data for that read.
    logic        rd_d;
`else
    logic        unused_mem_in;
    assign unused_mem_in = ^mem_in;
`endif

    assign ready = (state == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cursor      <= 11'd0;
            col         <= 7'd0;
            mem_address <= 12'd0;
            mem_out     <= 8'd0;
            mem_we      <= 1'b0;
            lat_d       <= 8'd0;
            lat_a       <= 8'd0;
`ifdef TEXT_WRITER_SCROLL_EN
            rd_d        <= 1'b0;
`endif
        end else begin
`ifdef TEXT_WRITER_SCROLL_EN
            rd_d <= (state == SCRD);
`endif
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (valid) begin
                        lat_d <= data;
                        lat_a <= attr;
                        case (data)
                            8'h0D: begin
                                cursor <= cursor - {4'd0, col};
                                col    <= 7'd0;
                            end
                            8'h0A: begin
                                if (cursor < 11'd1920) begin
                                    cursor <= cursor + 11'd80;
                                end else begin
`ifdef TEXT_WRITER_SCROLL_EN
                                    state       <= SCRD;
                                    mem_address <= 12'd160;
`else
                                    cursor <= cursor - 11'd1920;
`endif
                                end
                            end
                            8'h08: begin
                                if (cursor != 11'd0) begin
                                    cursor <= cursor - 11'd1;
                                    col    <= (col == 7'd0) ? 7'd79
                                                            : col - 7'd1;
                                end
                            end
                            8'h0C: begin
                                state       <= CLR;
                                mem_address <= 12'd0;
                                mem_out     <= 8'h20;
                                mem_we      <= 1'b1;
                            end
                            default: begin
                                state       <= WCHR;
                                mem_address <= {cursor, 1'b0};
                                mem_out     <= data;
                                mem_we      <= 1'b1;
                            end
                        endcase
                    end
                end
                WCHR: begin
                    mem_address <= {cursor, 1'b1};
                    mem_out     <= lat_a;
                    state       <= WATR;
                end
                WATR: begin
                    mem_we <= 1'b0;
                    if (cursor == 11'd1999) begin
                        col <= 7'd0;
`ifdef TEXT_WRITER_SCROLL_EN
                        cursor      <= 11'd1920;
                        state       <= SCRD;
                        mem_address <= 12'd160;
`else
                        cursor <= 11'd0;
                        state  <= IDLE;
`endif
                    end else begin
                        cursor <= cursor + 11'd1;
                        col    <= (col == 7'd79) ? 7'd0 : col + 7'd1;
                        state  <= IDLE;
                    end
                end
`ifdef TEXT_WRITER_SCROLL_EN
                // Reads and writes are interleaved one byte apart so the
                // registered write data has a full cycle to arrive:
                // R160 R161 W0 R162 W1 ... R3999 W3838 W3839.
                SCRD: begin
                    if (rd_d) mem_out <= mem_in;
                    if (mem_address == 12'd160) begin
                        mem_address <= 12'd161;
                    end else begin
                        mem_address <= mem_address - 12'd161;
                        mem_we      <= 1'b1;
                        state       <= SCWR;
                    end
                end
                SCWR: begin
                    if (rd_d) mem_out <= mem_in;
                    if (mem_address == 12'd3838) begin
                        mem_address <= 12'd3839;
                    end else if (mem_address == 12'd3839) begin
                        mem_address <= 12'd3840;
                        mem_out     <= 8'h20;
                        state       <= FILL;
                    end else begin
                        mem_address <= mem_address + 12'd162;
                        mem_we      <= 1'b0;
                        state       <= SCRD;
                    end
                end
                FILL: begin
                    if (mem_address == 12'd3999) begin
                        mem_we <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        mem_address <= mem_address + 12'd1;
                        mem_out     <= mem_address[0] ? 8'h20 : lat_a;
                    end
                end
`endif
                CLR: begin
                    if (mem_address == 12'd3999) begin
                        mem_we <= 1'b0;
                        cursor <= 11'd0;
                        col    <= 7'd0;
                        state  <= IDLE;
                    end else begin
                        mem_address <= mem_address + 12'd1;
                        mem_out     <= mem_address[0] ? 8'h20 : lat_a;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed self-checking bench for text_writer with a
// synchronous RAM model on the video RAM port.
module tb_text_writer;

    logic        clock;
    logic        reset;
    logic [7:0]  data;
    logic [7:0]  attr;
    logic        valid;
    logic        ready;
    logic [11:0] mem_address;
    logic [7:0]  mem_out;
    logic        mem_we;
    logic [7:0]  mem_in;
    logic [10:0] cursor;

    logic [7:0]  ram [0:4095];
    logic        preload = 1'b0;
    logic        hi_wr = 1'b0;

    int ncmp = 0;
    int nbad = 0;

    text_writer dut (
        .clock(clock), .reset(reset),
        .data(data), .attr(attr), .valid(valid), .ready(ready),
        .mem_address(mem_address), .mem_out(mem_out),
        .mem_we(mem_we), .mem_in(mem_in), .cursor(cursor)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 4000; i++)
                ram[i] <= (i[0] == 1'b0) ? 8'(48 + i / 160) : 8'h07;
        end else if (mem_we) begin
            ram[mem_address] <= mem_out;
            if (mem_address >= 12'd4000) hi_wr <= 1'b1;
        end
        mem_in <= ram[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] a,
                        output int low);
        int n;
        n = 0;
        @(negedge clock);
        data = d; attr = a; valid = 1'b1;
        while (!ready && n < 20000) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1 valid = 1'b0;
        low = 0;
        while (!ready && low < 20000) begin
            @(posedge clock);
            #1 low++;
        end
        chk("done", ready, 1);
    endtask

    int low;
    int bad;
    logic [7:0] e;

    initial begin
        reset = 1'b1; valid = 1'b0; data = 8'h00; attr = 8'h00;
        repeat (2) @(negedge clock);
        chk("rst_ready", ready, 1);
        chk("rst_cursor", cursor, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_out", mem_out, 0);
        reset = 1'b0;

        send(8'h41, 8'h17, low);
        chk("chr_mem0", ram[0], 8'h41);
        chk("chr_mem1", ram[1], 8'h17);
        chk("chr_cursor", cursor, 1);
        chk("chr_low", low, 2);

        send(8'h08, 8'h00, low);
        chk("bs_1to0", cursor, 0);
        send(8'h08, 8'h00, low);
        chk("bs_at0", cursor, 0);

        send(8'h0C, 8'h1F, low);
        chk("ff_low", low, 4000);
        chk("ff_cursor", cursor, 0);
        bad = 0;
        for (int i = 0; i < 4000; i++)
            if (ram[i] !== ((i[0] == 1'b0) ? 8'h20 : 8'h1F)) bad++;
        chk("ff_ram", bad, 0);

        for (int i = 0; i < 5; i++) send(8'h61, 8'h07, low);
        send(8'h08, 8'h00, low);
        chk("bs_5to4", cursor, 4);
        send(8'h0A, 8'h00, low);
        send(8'h61, 8'h07, low);
        chk("pre_cr", cursor, 85);

        @(negedge clock);
        data = 8'h0D; attr = 8'h00; valid = 1'b1;
        @(posedge clock);
        #1 chk("cr_cursor", cursor, 80);
        chk("cr_ready", ready, 1);
        chk("cr_we", mem_we, 0);
        data = 8'h0A;
        @(posedge clock);
        #1 chk("lf_cursor", cursor, 160);
        chk("lf_ready", ready, 1);
        chk("lf_we", mem_we, 0);
        valid = 1'b0;

        for (int i = 0; i < 22; i++) send(8'h0A, 8'h00, low);
        send(8'h08, 8'h00, low);
        send(8'h0A, 8'h00, low);
        chk("pre_scroll", cursor, 1999);

        @(negedge clock);
        preload = 1'b1;
        @(posedge clock);
        #1 preload = 1'b0;

        send(8'h58, 8'h4E, low);
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
`ifdef TEXT_WRITER_SCROLL_EN
            if (i >= 3840) e = (i[0] == 1'b0) ? 8'h20 : 8'h4E;
            else if (i == 3838) e = 8'h58;
            else if (i == 3839) e = 8'h4E;
            else e = (i[0] == 1'b0) ? 8'(49 + i / 160) : 8'h07;
`else
            if (i == 3998) e = 8'h58;
            else if (i == 3999) e = 8'h4E;
            else e = (i[0] == 1'b0) ? 8'(48 + i / 160) : 8'h07;
`endif
            if (ram[i] !== e) bad++;
        end
        chk("ovf_ram", bad, 0);
`ifdef TEXT_WRITER_SCROLL_EN
        chk("ovf_cursor", cursor, 1920);
        chk("ovf_low", low, 7842);
`else
        chk("ovf_cursor", cursor, 0);
        chk("ovf_low", low, 2);
`endif

        @(negedge clock);
`ifdef TEXT_WRITER_SCROLL_EN
        data = 8'h0A;
`else
        data = 8'h0C;
`endif
        attr = 8'h33; valid = 1'b1;
        @(posedge clock);
        #1 valid = 1'b0;
        repeat (100) @(posedge clock);
        #3 chk("mid_busy", ready, 0);
        reset = 1'b1;
        #1 chk("abort_ready", ready, 1);
        chk("abort_cursor", cursor, 0);
        chk("abort_we", mem_we, 0);
        @(negedge clock);
        reset = 1'b0;

        send(8'h5A, 8'h17, low);
        chk("post_mem0", ram[0], 8'h5A);
        chk("post_mem1", ram[1], 8'h17);
        chk("post_cursor", cursor, 1);
        chk("no_high_write", hi_wr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule
